// File: rtl/riscv_test_ctrl.sv
// Test controller beside a RISC-V core: core reset sequencing, cycle/instret counting,
// tohost end-of-test, timeout/hang abort. Optional signature capture: RISCV_TEST_SIG_CAPTURE_EN.
module riscv_test_ctrl #(
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned MAX_CYCLES  = 100,
  parameter int unsigned HANG_CYCLES = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0018,
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] SIG_BASE    = 32'h0000_0100,
  parameter int unsigned SIG_DEPTH   = 8,
  localparam int unsigned SIG_IW     = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  input  logic              memwrite,
  input  logic [31:0]       aluout,
  input  logic [31:0]       writedata,
  output logic              core_reset,
  output logic [1:0]        state,
  output logic              done,
  output logic              pass,
  output logic [30:0]       fail_code,
  output logic              timeout,
  output logic              hung,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  input  logic [SIG_IW-1:0] sig_idx,
  output logic [31:0]       sig_data,
  output logic [SIG_DEPTH-1:0] sig_valid
);

  // state   | meaning
  // S_HOLD  | core held in reset for RST_CYCLES cycles
  // S_RUN   | core running, monitoring active
  // S_DONE  | tohost termination seen (terminal)
  // S_ABORT | timeout or hung pc (terminal)
  typedef enum logic [1:0] {S_HOLD = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_ABORT = 2'd3} state_t;

  localparam int unsigned HOLD_W  = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int unsigned STUCK_W = $clog2(HANG_CYCLES + 1);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STUCK_W-1:0] stuck_cnt;
  logic [31:0]        pc_prev;

  logic        first_run, pc_same, tohost_hit, hang_hit, time_hit, hold_done;
  logic        core_reset_d, done_d, pass_d, timeout_d, hung_d;
  logic [30:0] fail_code_d;

  // cycle_count only reads zero before the first RUN edge since it saturates
  assign first_run  = (cycle_count == '0);
  assign pc_same    = !first_run && (pc == pc_prev);
  assign tohost_hit = memwrite && (aluout == TOHOST_ADDR) && writedata[0];
  assign hang_hit   = pc_same && (stuck_cnt == STUCK_W'(HANG_CYCLES - 1));
  assign time_hit   = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign hold_done  = (hold_cnt == HOLD_W'(RST_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HOLD;
      core_reset <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= '0;
      timeout    <= 1'b0;
      hung       <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_reset <= core_reset_d;
      done       <= done_d;
      pass       <= pass_d;
      fail_code  <= fail_code_d;
      timeout    <= timeout_d;
      hung       <= hung_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:  if (hold_done) state_d = S_RUN;
      S_RUN: begin
        if (tohost_hit)    state_d = S_DONE;
        else if (hang_hit) state_d = S_ABORT;
        else if (time_hit) state_d = S_ABORT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    core_reset_d = (state_d == S_HOLD);
    done_d       = done;
    pass_d       = pass;
    fail_code_d  = fail_code;
    timeout_d    = timeout;
    hung_d       = hung;
    if (state_q == S_RUN) begin
      if (tohost_hit) begin
        done_d      = 1'b1;
        pass_d      = (writedata == 32'd1);
        fail_code_d = (writedata == 32'd1) ? 31'd0 : writedata[31:1];
      end else if (hang_hit) begin
        hung_d = 1'b1;
      end else if (time_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign state = state_q;

  // Counters update on every RUN edge, including the exit edge, then freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt      <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
      pc_prev       <= '0;
      stuck_cnt     <= '0;
    end else begin
      case (state_q)
        S_HOLD: if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          if (!pc_same && instret_count != '1) instret_count <= instret_count + CNT_W'(1);
          pc_prev   <= pc;
          stuck_cnt <= pc_same ? stuck_cnt + STUCK_W'(1) : '0;
        end
        default: ;
      endcase
    end
  end

  logic unused_bits;

`ifdef RISCV_TEST_SIG_CAPTURE_EN
  logic [31:0]          sig_mem [SIG_DEPTH];
  logic [31:0]          sig_off;
  logic                 sig_hit;
  logic [SIG_DEPTH-1:0] sig_valid_q;

  assign sig_off = aluout - SIG_BASE;
  assign sig_hit = (state_q == S_RUN) && memwrite && (aluout >= SIG_BASE)
                   && (aluout < SIG_BASE + 32'(4 * SIG_DEPTH));

  // Storage is deliberately not reset; only the valid flags are
  always_ff @(posedge clk) begin
    if (sig_hit) sig_mem[sig_off[2 +: SIG_IW]] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset)        sig_valid_q <= '0;
    else if (sig_hit) sig_valid_q[sig_off[2 +: SIG_IW]] <= 1'b1;
  end

  assign sig_data    = sig_mem[sig_idx];
  assign sig_valid   = sig_valid_q;
  assign unused_bits = ^{instr, sig_off};
`else
  assign sig_data    = '0;
  assign sig_valid   = '0;
  assign unused_bits = ^{instr, sig_idx, SIG_BASE};
`endif

endmodule
